ovf_wb_stage: RTL and testbench

OVF_WB_STAGE -- requirements
Module: ovf_wb_stage

---
 rtl/ovf_wb_if.sv | 35 +++
 rtl/ovf_wb_stage.sv | 98 +++++++++
 tb/tb_ovf_wb_stage.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ovf_wb_if.sv
// Bundles the add/sub result stream, trap handshake and overflow status
// seen by the writeback stage.
interface ovf_wb_if #(
  parameter int CNT_W = 16
);
  logic             valid_in;
  logic [31:0]      y_in;
  logic             pos_ovf;
  logic             neg_ovf;
  logic [4:0]       rd_in;
  logic             sat_en;
  logic             trap_ack;
  logic             clr_sticky;
  logic             wb_valid;
  logic [31:0]      wb_data;
  logic [4:0]       wb_rd;
  logic             trap_req;
  logic [1:0]       trap_cause;
  logic             stall;
  logic             sticky_pos;
  logic             sticky_neg;
  logic [CNT_W-1:0] ovf_count;

  modport master (
    output valid_in, y_in, pos_ovf, neg_ovf, rd_in, sat_en, trap_ack, clr_sticky,
    input  wb_valid, wb_data, wb_rd, trap_req, trap_cause, stall,
           sticky_pos, sticky_neg, ovf_count
  );

  modport slave (
    input  valid_in, y_in, pos_ovf, neg_ovf, rd_in, sat_en, trap_ack, clr_sticky,
    output wb_valid, wb_data, wb_rd, trap_req, trap_cause, stall,
           sticky_pos, sticky_neg, ovf_count
  );
endinterface

// File: rtl/ovf_wb_stage.sv
// Writeback stage for add/sub results: saturates or traps on overflow and keeps
// sticky overflow flags plus a saturating event counter. One-cycle latency; stall while trapped.
module ovf_wb_stage #(
  parameter int CNT_W = 16
) (
  input  logic     clk,
  input  logic     rst,
  ovf_wb_if.slave  bus
);

  typedef enum logic {IDLE, TRAP} state_t;

  state_t           state, state_nxt;
  logic             ovf;
  logic             wb_valid_q;
  logic [31:0]      wb_data_q;
  logic [4:0]       wb_rd_q;
  logic             trap_req_q;
  logic [1:0]       trap_cause_q;
  logic             sticky_pos_q;
  logic             sticky_neg_q;
  logic [CNT_W-1:0] cnt_q;

  // Overflow events only count while IDLE; a trapped stage sees held operands.
  assign ovf = (state == IDLE) & bus.valid_in & (bus.pos_ovf | bus.neg_ovf);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (ovf && !bus.sat_en) state_nxt = TRAP;
      TRAP: if (bus.trap_ack)       state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q   <= 1'b0;
      wb_data_q    <= '0;
      wb_rd_q      <= '0;
      trap_req_q   <= 1'b0;
      trap_cause_q <= 2'b00;
    end else if (state == TRAP) begin
      wb_valid_q <= 1'b0;
      if (bus.trap_ack) begin
        trap_req_q   <= 1'b0;
        trap_cause_q <= 2'b00;
      end
    end else if (!bus.valid_in) begin
      wb_valid_q <= 1'b0;
    end else if (!ovf) begin
      wb_valid_q <= 1'b1;
      wb_data_q  <= bus.y_in;
      wb_rd_q    <= bus.rd_in;
    end else if (bus.sat_en) begin
      wb_valid_q <= 1'b1;
      wb_data_q  <= bus.pos_ovf ? 32'h7FFF_FFFF : 32'h8000_0000;
      wb_rd_q    <= bus.rd_in;
    end else begin
      wb_valid_q   <= 1'b0;
      trap_req_q   <= 1'b1;
      trap_cause_q <= bus.pos_ovf ? 2'b01 : 2'b10;
    end
  end

  // A clear coinciding with an event restarts the history at that event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_pos_q <= 1'b0;
      sticky_neg_q <= 1'b0;
      cnt_q        <= '0;
    end else if (bus.clr_sticky) begin
      sticky_pos_q <= ovf & bus.pos_ovf;
      sticky_neg_q <= ovf & ~bus.pos_ovf;
      cnt_q        <= ovf ? CNT_W'(1) : '0;
    end else if (ovf) begin
      if (bus.pos_ovf) sticky_pos_q <= 1'b1;
      else             sticky_neg_q <= 1'b1;
      if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.wb_valid   = wb_valid_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.wb_rd      = wb_rd_q;
  assign bus.trap_req   = trap_req_q;
  assign bus.trap_cause = trap_cause_q;
  assign bus.stall      = (state == TRAP);
  assign bus.sticky_pos = sticky_pos_q;
  assign bus.sticky_neg = sticky_neg_q;
  assign bus.ovf_count  = cnt_q;

endmodule

// File: tb/tb_ovf_wb_stage.sv
// Drives a 16-bit-counter and a 4-bit-counter instance with identical stimulus
// and compares both against a transaction-level model of the writeback rules.
module tb_ovf_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, pos_ovf, neg_ovf, sat_en, trap_ack, clr_sticky;
  logic [31:0] y_in;
  logic [4:0]  rd_in;

  int errors = 0;
  int checks = 0;

  ovf_wb_if #(.CNT_W(16)) b16 ();
  ovf_wb_if #(.CNT_W(4))  b4  ();

  ovf_wb_stage #(.CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));
  ovf_wb_stage #(.CNT_W(4))  dut4  (.clk(clk), .rst(rst), .bus(b4.slave));

  assign b16.valid_in = valid_in;   assign b4.valid_in = valid_in;
  assign b16.y_in = y_in;           assign b4.y_in = y_in;
  assign b16.pos_ovf = pos_ovf;     assign b4.pos_ovf = pos_ovf;
  assign b16.neg_ovf = neg_ovf;     assign b4.neg_ovf = neg_ovf;
  assign b16.rd_in = rd_in;         assign b4.rd_in = rd_in;
  assign b16.sat_en = sat_en;       assign b4.sat_en = sat_en;
  assign b16.trap_ack = trap_ack;   assign b4.trap_ack = trap_ack;
  assign b16.clr_sticky = clr_sticky; assign b4.clr_sticky = clr_sticky;

  always #5 clk = ~clk;

  // Reference model state
  bit          m_trap, m_wbv, m_sp, m_sn;
  logic [31:0] m_data;
  logic [4:0]  m_rd;
  logic [1:0]  m_cause;
  int          m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_trap = 0; m_wbv = 0; m_sp = 0; m_sn = 0;
    m_data = '0; m_rd = '0; m_cause = 2'b00; m_cnt = 0;
  endtask

  // One clock edge worth of behaviour, computed from the currently driven inputs.
  task automatic model_step();
    bit ev, evpos;
    ev    = !m_trap && valid_in && (pos_ovf || neg_ovf);
    evpos = pos_ovf;
    if (clr_sticky) begin m_sp = 0; m_sn = 0; m_cnt = 0; end
    if (ev) begin
      if (evpos) m_sp = 1; else m_sn = 1;
      m_cnt++;
    end
    if (m_trap) begin
      m_wbv = 0;
      if (trap_ack) begin m_trap = 0; m_cause = 2'b00; end
    end else if (!valid_in) begin
      m_wbv = 0;
    end else if (!ev) begin
      m_wbv = 1; m_data = y_in; m_rd = rd_in;
    end else if (sat_en) begin
      m_wbv = 1; m_data = evpos ? 32'h7FFF_FFFF : 32'h8000_0000; m_rd = rd_in;
    end else begin
      m_wbv = 0; m_trap = 1; m_cause = evpos ? 2'b01 : 2'b10;
    end
  endtask

  task automatic check_all();
    int c16, c4;
    c16 = (m_cnt > 65535) ? 65535 : m_cnt;
    c4  = (m_cnt > 15) ? 15 : m_cnt;
    check("d16.wb_valid",   64'(b16.wb_valid),   64'(m_wbv));
    check("d16.wb_data",    64'(b16.wb_data),    64'(m_data));
    check("d16.wb_rd",      64'(b16.wb_rd),      64'(m_rd));
    check("d16.trap_req",   64'(b16.trap_req),   64'(m_trap));
    check("d16.trap_cause", 64'(b16.trap_cause), 64'(m_cause));
    check("d16.stall",      64'(b16.stall),      64'(m_trap));
    check("d16.sticky_pos", 64'(b16.sticky_pos), 64'(m_sp));
    check("d16.sticky_neg", 64'(b16.sticky_neg), 64'(m_sn));
    check("d16.ovf_count",  64'(b16.ovf_count),  64'(c16));
    check("d4.wb_valid",    64'(b4.wb_valid),    64'(m_wbv));
    check("d4.wb_data",     64'(b4.wb_data),     64'(m_data));
    check("d4.trap_req",    64'(b4.trap_req),    64'(m_trap));
    check("d4.stall",       64'(b4.stall),       64'(m_trap));
    check("d4.sticky_pos",  64'(b4.sticky_pos),  64'(m_sp));
    check("d4.sticky_neg",  64'(b4.sticky_neg),  64'(m_sn));
    check("d4.ovf_count",   64'(b4.ovf_count),   64'(c4));
  endtask

  task automatic drive(input bit v, input logic [31:0] y, input bit p, input bit n,
                       input logic [4:0] rd, input bit sat, input bit ack, input bit clr);
    valid_in = v; y_in = y; pos_ovf = p; neg_ovf = n;
    rd_in = rd; sat_en = sat; trap_ack = ack; clr_sticky = clr;
  endtask

  // Advance one edge and compare 1 ns later.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    drive(0, '0, 0, 0, '0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    #2;
    check_all();
    @(posedge clk); #1;
    rst = 1'b0;
    check_all();

    // Plain writeback
    drive(1, 32'h0000_0005, 0, 0, 5'd3, 1, 0, 0); cycle();
    check("nov.wb_data", 64'(b16.wb_data), 64'h5);
    check("nov.count", 64'(b16.ovf_count), 64'h0);

    // Saturation, positive then both flags (positive wins)
    drive(1, 32'h8000_0000, 1, 0, 5'd7, 1, 0, 0); cycle();
    check("sat.wb_data", 64'(b16.wb_data), 64'h7FFF_FFFF);
    drive(1, 32'h1234_0000, 1, 1, 5'd8, 1, 0, 1); cycle();
    check("both.sticky_neg", 64'(b16.sticky_neg), 64'h0);
    drive(1, 32'h7FFF_FFF0, 0, 1, 5'd9, 1, 0, 0); cycle();
    check("satneg.wb_data", 64'(b16.wb_data), 64'h8000_0000);

    // Trap on negative overflow; inputs toggle while trapped, then acknowledge
    drive(1, 32'h0BAD_0000, 0, 1, 5'd4, 0, 0, 0); cycle();
    check("trap.cause", 64'(b16.trap_cause), 64'h2);
    for (int i = 0; i < 3; i++) begin
      drive(i[0], $urandom, 1, i[1], 5'(i), 1, 0, 0); cycle();
    end
    drive(0, '0, 0, 0, '0, 0, 1, 0); cycle();
    check("ack.stall", 64'(b16.stall), 64'h0);
    drive(1, 32'h0000_0042, 0, 0, 5'd1, 0, 1, 0); cycle();

    // Counter saturation on the narrow instance, then clear with a coincident event
    for (int i = 0; i < 17; i++) begin
      drive(1, $urandom, 1, 0, 5'd2, 1, 0, 0); cycle();
    end
    check("cnt4.sat", 64'(b4.ovf_count), 64'hF);
    drive(1, 32'h0, 0, 1, 5'd2, 1, 0, 1); cycle();
    check("clr.cnt4", 64'(b4.ovf_count), 64'h1);

    // Reset asserted mid-cycle while trapped
    drive(1, 32'h0, 1, 0, 5'd6, 0, 0, 0); cycle();
    drive(0, '0, 0, 0, '0, 0, 0, 0);
    #3 rst = 1'b1;
    model_reset();
    #1 check_all();
    @(posedge clk); #1;
    rst = 1'b0;
    check_all();
    drive(1, 32'h0000_0077, 0, 0, 5'd12, 0, 0, 0); cycle();

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(3) != 0), $urandom,
            ($urandom_range(7) == 0), ($urandom_range(7) == 0),
            5'($urandom), $urandom_range(1), ($urandom_range(2) == 0),
            ($urandom_range(19) == 0));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
